cache_fsm_l2a: RTL and testbench
================================

Name: cache_fsm_L2a

Overview:
- Direct-mapped, write-back, write-allocate L2 controller for processor A.
- Serves the L1a controller's three request types: block read (allocate), single-word write-through (inclusion), and dirty block write-back.
- On a miss it fetches blocks from L3 and writes its own dirty victims back to L3.
- Keeps saturating hit/miss statistics counters.

Parameters:
- PROCESSOR_ID, 2'd0, value addr[31:30] must match for a request to be accepted.
- NUM_SETS_L2, 64, number of L2 lines.
- INDEX_WIDTH_L2, 6, log2(NUM_SETS_L2).
- BLOCK_WIDTH, 128, line width in bits (= MAIN_MEMORY_DATA_WIDTH).
- WORD_WIDTH, 32, word width in bits (= DATA_WIDTH).
- STAT_WIDTH, 16, width of the hit/miss counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- read_from_L2a_request  in  1  L1a block read; held until L2a_ready.
- write_to_L2a_request  in  1  L1a word write; held until write_to_L2a_verified.
- write_back_to_L2a_request  in  1  L1a block write-back; held until write_back_to_L2a_verified.
- cache_L2a_memory_address  in  32  request address.
- cache_1a_write_data_to_L2a  in  WORD_WIDTH  word-write data.
- write_back_to_L2a_data  in  BLOCK_WIDTH  write-back block.
- write_data_to_L1a_from_L2a  out  BLOCK_WIDTH  block returned to L1a.
- L2a_ready  out  1  1-cycle pulse; read data valid.
- write_to_L2a_verified  out  1  1-cycle pulse.
- write_back_to_L2a_verified  out  1  1-cycle pulse.
- L3_address  out  32  L3 block address (offset bits zero).
- L3_read_request  out  1  held until L3_ready.
- L3_write_back_request  out  1  held until L3_write_back_verified.
- L3_write_data  out  BLOCK_WIDTH  victim block.
- L3_read_data  in  BLOCK_WIDTH  fill block.
- L3_ready  in  1  fill valid (1 cycle).
- L3_write_back_verified  in  1  victim accepted (1 cycle).
- L2a_cache_hit  out  1  1-cycle pulse in COMPARE.
- L2a_cache_miss  out  1  1-cycle pulse in COMPARE.
- L2a_hit_count  out  STAT_WIDTH  saturating hit count.
- L2a_miss_count  out  STAT_WIDTH  saturating miss count.

Behaviour:
- Address split:
  - processor id = addr[31:30]
  - tag = addr[29:10]
  - index = addr[9:4]
  - word offset = addr[3:2]
  - addr[1:0] ignored
- Reset (asynchronous):
  - all outputs 0, counters 0, state IDLE.
  - valid/dirty/tag/data arrays cleared.
  - reset mid-transaction drops any L3 request immediately; the aborted transaction is never responded to.
- Request latch in IDLE:
  - Accept only if addr[31:30]==PROCESSOR_ID.
  - Simultaneous requests are prioritised write-back > word write > read.
  - Address, word data, block data and request type are registered; go to COMPARE.
- COMPARE (1 cycle):
  - hit = valid[index] && tag match.
  - Pulse L2a_cache_hit or L2a_cache_miss; increment the matching counter, saturating at all-ones.
  - Hit → RESPOND.
  - Miss:
    - victim valid && dirty → WRITE_BACK.
    - miss on a block write-back → INSTALL (no fetch).
    - otherwise → ALLOCATE.
- WRITE_BACK:
  - Drive L3_write_back_request=1, L3_address={stored victim tag, index, 4'b0}, L3_write_data=line.
  - On L3_write_back_verified: clear dirty[index].
  - Next state: INSTALL for block write-back requests, else ALLOCATE.
- ALLOCATE:
  - Drive L3_read_request=1 with the request block address.
  - On L3_ready: line=L3_read_data, tag written, valid=1, dirty=0; → RESPOND.
- INSTALL:
  - line=write-back block, tag written, valid=1, dirty=1; → RESPOND.
- RESPOND (1 cycle), by request type:
  - Read: write_data_to_L1a_from_L2a=line, L2a_ready=1.
  - Word write: merge word at offset*32 into the line, dirty=1, write_to_L2a_verified=1.
  - Block write-back hit: overwrite the line, dirty=1, write_back_to_L2a_verified=1.
  - Then → IDLE.
- Timing:
  - Hit latency: request seen in IDLE → response pulse 2 cycles later.
  - Clean miss adds L3 latency + 1 cycle.
  - Dirty miss adds the write-back handshake before the fill.
- write_data_to_L1a_from_L2a holds its value until the next read response.
- Requests from a non-matching processor id are ignored; the block stays in IDLE.
- A request deasserted before its response is a protocol violation; the transaction still completes internally.

Decomposition:
- Existing shared cache package holds:
  - state_t enum: IDLE, COMPARE, WRITE_BACK, ALLOCATE, INSTALL, RESPOND
  - req_t enum: REQ_READ, REQ_WRITE, REQ_WB
  - L2 geometry constants: INDEX_WIDTH_L2, tag/offset slice positions
- Sub-module sat_counter (STAT_WIDTH, increment enable, saturating), instantiated twice.

Test Plan:
- Cold read 0x0000_0040 → 1 miss; L3_read_request at addr 0x40 until L3_ready with 128'hA..; L2a_ready pulse returns 128'hA..; miss_count=1.
- Repeat read 0x40 → L2a_cache_hit; L2a_ready exactly 2 cycles after request; no L3 activity; hit_count=1.
- Word write 0x48 data 32'hDEADBEEF after the fill → hit; write_to_L2a_verified; subsequent read returns bits[95:64]=DEADBEEF; line dirty.
- Read 0x0000_0440 (same index 4, new tag) → L3_write_back_request to 0x40 carrying the merged line; after verify, fill from 0x440; L2a_ready.
- Simultaneous read + write-back requests → write-back serviced first; write_back_to_L2a_verified pulses before L2a_ready.
- Assert reset during ALLOCATE → L3_read_request drops the same cycle; all outputs 0; address 0x40 misses again afterwards.

Source files
------------

// File: rtl/cache_fsm_l2a_pkg.sv
// Shared definitions for the L2a cache controller.
//   - state_t : controller FSM states
//   - req_t   : latched L1a request kind
//   - L2 geometry and address-slice positions
//   - merge_word : replaces one 32-bit word inside a 128-bit line
package cache_fsm_l2a_pkg;

  localparam int NUM_SETS_L2     = 64;
  localparam int INDEX_WIDTH_L2  = 6;
  localparam int BLOCK_WIDTH     = 128;
  localparam int WORD_WIDTH      = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_WIDTH / WORD_WIDTH;

  // Address layout: [31:30] processor id, [29:10] tag, [9:4] index,
  // [3:2] word offset, [1:0] byte (ignored).
  localparam int OFFSET_LSB   = 2;
  localparam int OFFSET_WIDTH = 2;
  localparam int INDEX_LSB    = OFFSET_LSB + OFFSET_WIDTH;
  localparam int TAG_LSB      = INDEX_LSB + INDEX_WIDTH_L2;
  localparam int PID_LSB      = 30;
  localparam int TAG_WIDTH    = PID_LSB - TAG_LSB;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    INSTALL,
    RESPOND
  } state_t;

  typedef enum logic [1:0] {
    REQ_READ,
    REQ_WRITE,
    REQ_WB
  } req_t;

  // Word 0 occupies bits [31:0], word 3 occupies bits [127:96].
  function automatic logic [BLOCK_WIDTH-1:0] merge_word(
    input logic [BLOCK_WIDTH-1:0]  line,
    input logic [OFFSET_WIDTH-1:0] offset,
    input logic [WORD_WIDTH-1:0]   word
  );
    logic [BLOCK_WIDTH-1:0] merged;
    merged = line;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      if (offset == OFFSET_WIDTH'(w)) begin
        merged[w*WORD_WIDTH +: WORD_WIDTH] = word;
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/cache_fsm_l2a_sat_counter.sv
// Saturating up-counter used for the L2a hit/miss statistics.
//   clk, reset : clock, asynchronous active-high reset (clears count)
//   inc        : add one this cycle unless already all-ones
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fsm_l2a.sv
// Direct-mapped, write-back, write-allocate L2 controller for processor A.
// Serves three L1a request kinds: block read, single-word write and dirty
// block write-back. Misses fetch from L3; dirty victims are written to L3.
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   read_from_L2a_request               L1a block read, held until L2a_ready
//   write_to_L2a_request                L1a word write, held until verified
//   write_back_to_L2a_request           L1a block write-back, held until verified
//   cache_L2a_memory_address            request address
//   cache_1a_write_data_to_L2a          word-write data
//   write_back_to_L2a_data              write-back block
//   write_data_to_L1a_from_L2a          block returned on a read (held)
//   L2a_ready / write_to_L2a_verified / write_back_to_L2a_verified
//                                       1-cycle response pulses
//   L3_address, L3_read_request, L3_write_back_request, L3_write_data
//                                       L3 request side (requests held)
//   L3_read_data, L3_ready, L3_write_back_verified
//                                       L3 response side
//   L2a_cache_hit / L2a_cache_miss      1-cycle lookup result pulses
//   L2a_hit_count / L2a_miss_count      saturating statistics
module cache_fsm_l2a
  import cache_fsm_l2a_pkg::*;
#(
  parameter logic [1:0] PROCESSOR_ID = 2'd0,
  parameter int         STAT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   read_from_L2a_request,
  input  logic                   write_to_L2a_request,
  input  logic                   write_back_to_L2a_request,
  input  logic [31:0]            cache_L2a_memory_address,
  input  logic [WORD_WIDTH-1:0]  cache_1a_write_data_to_L2a,
  input  logic [BLOCK_WIDTH-1:0] write_back_to_L2a_data,
  output logic [BLOCK_WIDTH-1:0] write_data_to_L1a_from_L2a,
  output logic                   L2a_ready,
  output logic                   write_to_L2a_verified,
  output logic                   write_back_to_L2a_verified,
  output logic [31:0]            L3_address,
  output logic                   L3_read_request,
  output logic                   L3_write_back_request,
  output logic [BLOCK_WIDTH-1:0] L3_write_data,
  input  logic [BLOCK_WIDTH-1:0] L3_read_data,
  input  logic                   L3_ready,
  input  logic                   L3_write_back_verified,
  output logic                   L2a_cache_hit,
  output logic                   L2a_cache_miss,
  output logic [STAT_WIDTH-1:0]  L2a_hit_count,
  output logic [STAT_WIDTH-1:0]  L2a_miss_count
);

  // Cache arrays.
  logic                   valid_q [NUM_SETS_L2];
  logic                   dirty_q [NUM_SETS_L2];
  logic [TAG_WIDTH-1:0]   tag_q   [NUM_SETS_L2];
  logic [BLOCK_WIDTH-1:0] data_q  [NUM_SETS_L2];

  // Latched request.
  state_t                    state;
  req_t                      req_type;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic [INDEX_WIDTH_L2-1:0] req_index;
  logic [OFFSET_WIDTH-1:0]   req_offset;
  logic [WORD_WIDTH-1:0]     req_word;
  logic [BLOCK_WIDTH-1:0]    req_block;

  // Byte-select bits play no part in a block/word controller.
  logic unused_byte_bits;
  assign unused_byte_bits = ^cache_L2a_memory_address[OFFSET_LSB-1:0];

  logic   accept;
  req_t   incoming_type;
  logic   hit;
  logic   hit_inc;
  logic   miss_inc;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    accept        = 1'b0;
    incoming_type = REQ_READ;
    if (cache_L2a_memory_address[31:PID_LSB] == PROCESSOR_ID) begin
      if (write_back_to_L2a_request) begin
        accept        = 1'b1;
        incoming_type = REQ_WB;
      end else if (write_to_L2a_request) begin
        accept        = 1'b1;
        incoming_type = REQ_WRITE;
      end else if (read_from_L2a_request) begin
        accept        = 1'b1;
        incoming_type = REQ_READ;
      end
    end
    hit      = valid_q[req_index] && (tag_q[req_index] == req_tag);
    hit_inc  = (state == COMPARE) && hit;
    miss_inc = (state == COMPARE) && !hit;
  end

  sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (L2a_hit_count)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (L2a_miss_count)
  );

  // Block address of the pending request, offset bits forced to zero.
  logic [31:0] req_block_addr;
  assign req_block_addr = {PROCESSOR_ID, req_tag, req_index, 4'b0};

  // NOTE: all state here is sequential and assigned with <= so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                      <= IDLE;
      req_type                   <= REQ_READ;
      req_tag                    <= '0;
      req_index                  <= '0;
      req_offset                 <= '0;
      req_word                   <= '0;
      req_block                  <= '0;
      write_data_to_L1a_from_L2a <= '0;
      L2a_ready                  <= 1'b0;
      write_to_L2a_verified      <= 1'b0;
      write_back_to_L2a_verified <= 1'b0;
      L3_address                 <= '0;
      L3_read_request            <= 1'b0;
      L3_write_back_request      <= 1'b0;
      L3_write_data              <= '0;
      L2a_cache_hit              <= 1'b0;
      L2a_cache_miss             <= 1'b0;
      // NOTE: the line arrays are flop-based and must come out of reset
      // empty, so they are cleared here rather than left to a RAM macro.
      for (int i = 0; i < NUM_SETS_L2; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      // Response and lookup pulses last exactly one cycle.
      L2a_ready                  <= 1'b0;
      write_to_L2a_verified      <= 1'b0;
      write_back_to_L2a_verified <= 1'b0;
      L2a_cache_hit              <= 1'b0;
      L2a_cache_miss             <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            req_type   <= incoming_type;
            req_tag    <= cache_L2a_memory_address[PID_LSB-1:TAG_LSB];
            req_index  <= cache_L2a_memory_address[TAG_LSB-1:INDEX_LSB];
            req_offset <= cache_L2a_memory_address[INDEX_LSB-1:OFFSET_LSB];
            req_word   <= cache_1a_write_data_to_L2a;
            req_block  <= write_back_to_L2a_data;
            state      <= COMPARE;
          end
        end

        COMPARE: begin
          if (hit) begin
            L2a_cache_hit <= 1'b1;
            state         <= RESPOND;
          end else begin
            L2a_cache_miss <= 1'b1;
            if (valid_q[req_index] && dirty_q[req_index]) begin
              // Victim address is rebuilt from the tag stored in the line.
              L3_write_back_request <= 1'b1;
              L3_address            <= {PROCESSOR_ID, tag_q[req_index], req_index, 4'b0};
              L3_write_data         <= data_q[req_index];
              state                 <= WRITE_BACK;
            end else if (req_type == REQ_WB) begin
              // The whole block arrives from L1a, so nothing is fetched.
              state <= INSTALL;
            end else begin
              L3_read_request <= 1'b1;
              L3_address      <= req_block_addr;
              state           <= ALLOCATE;
            end
          end
        end

        WRITE_BACK: begin
          if (L3_write_back_verified) begin
            L3_write_back_request <= 1'b0;
            dirty_q[req_index]    <= 1'b0;
            if (req_type == REQ_WB) begin
              state <= INSTALL;
            end else begin
              L3_read_request <= 1'b1;
              L3_address      <= req_block_addr;
              state           <= ALLOCATE;
            end
          end
        end

        ALLOCATE: begin
          if (L3_ready) begin
            L3_read_request    <= 1'b0;
            data_q[req_index]  <= L3_read_data;
            tag_q[req_index]   <= req_tag;
            valid_q[req_index] <= 1'b1;
            dirty_q[req_index] <= 1'b0;
            state              <= RESPOND;
          end
        end

        INSTALL: begin
          data_q[req_index]  <= req_block;
          tag_q[req_index]   <= req_tag;
          valid_q[req_index] <= 1'b1;
          dirty_q[req_index] <= 1'b1;
          state              <= RESPOND;
        end

        RESPOND: begin
          unique case (req_type)
            REQ_READ: begin
              write_data_to_L1a_from_L2a <= data_q[req_index];
              L2a_ready                  <= 1'b1;
            end
            REQ_WRITE: begin
              data_q[req_index]     <= merge_word(data_q[req_index], req_offset, req_word);
              dirty_q[req_index]    <= 1'b1;
              write_to_L2a_verified <= 1'b1;
            end
            REQ_WB: begin
              data_q[req_index]          <= req_block;
              dirty_q[req_index]         <= 1'b1;
              write_back_to_L2a_verified <= 1'b1;
            end
            default: ;
          endcase
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fsm_l2a.sv
module tb_cache_fsm_l2a;
  import cache_fsm_l2a_pkg::*;

  // Narrow counters so saturation is reachable in a short run.
  localparam int SW      = 4;
  localparam int L3_LAT  = 2;
  localparam int TIMEOUT = 200;

  logic             clk;
  logic             reset;
  logic             read_from_L2a_request;
  logic             write_to_L2a_request;
  logic             write_back_to_L2a_request;
  logic [31:0]      cache_L2a_memory_address;
  logic [31:0]      cache_1a_write_data_to_L2a;
  logic [127:0]     write_back_to_L2a_data;
  logic [127:0]     write_data_to_L1a_from_L2a;
  logic             L2a_ready;
  logic             write_to_L2a_verified;
  logic             write_back_to_L2a_verified;
  logic [31:0]      L3_address;
  logic             L3_read_request;
  logic             L3_write_back_request;
  logic [127:0]     L3_write_data;
  logic [127:0]     L3_read_data;
  logic             L3_ready;
  logic             L3_write_back_verified;
  logic             L2a_cache_hit;
  logic             L2a_cache_miss;
  logic [SW-1:0]    L2a_hit_count;
  logic [SW-1:0]    L2a_miss_count;

  cache_fsm_l2a #(.PROCESSOR_ID(2'd0), .STAT_WIDTH(SW)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .read_from_L2a_request      (read_from_L2a_request),
    .write_to_L2a_request       (write_to_L2a_request),
    .write_back_to_L2a_request  (write_back_to_L2a_request),
    .cache_L2a_memory_address   (cache_L2a_memory_address),
    .cache_1a_write_data_to_L2a (cache_1a_write_data_to_L2a),
    .write_back_to_L2a_data     (write_back_to_L2a_data),
    .write_data_to_L1a_from_L2a (write_data_to_L1a_from_L2a),
    .L2a_ready                  (L2a_ready),
    .write_to_L2a_verified      (write_to_L2a_verified),
    .write_back_to_L2a_verified (write_back_to_L2a_verified),
    .L3_address                 (L3_address),
    .L3_read_request            (L3_read_request),
    .L3_write_back_request      (L3_write_back_request),
    .L3_write_data              (L3_write_data),
    .L3_read_data               (L3_read_data),
    .L3_ready                   (L3_ready),
    .L3_write_back_verified     (L3_write_back_verified),
    .L2a_cache_hit              (L2a_cache_hit),
    .L2a_cache_miss             (L2a_cache_miss),
    .L2a_hit_count              (L2a_hit_count),
    .L2a_miss_count             (L2a_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // L3 contents are a fixed pattern derived from the block address.
  function automatic logic [127:0] pat(input logic [31:0] a);
    return {4{32'hA000_0000 | a}};
  endfunction

  typedef struct {
    req_t         kind;
    logic [127:0] data;
  } resp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } wb_t;

  typedef struct {
    req_t         kind;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] wbdata;
    bit           exp_hit;
    bit           exp_fill;
    bit           exp_wb;
    logic [31:0]  exp_wb_addr;
    logic [127:0] exp_wb_data;
    logic [127:0] exp_rdata;
  } vec_t;

  resp_t resp_q[$];
  wb_t   exp_wb_q[$];
  int    l3_rd_cnt = 0;
  int    l3_wb_cnt = 0;
  bit    l3_stall  = 0;
  int    exp_hits  = 0;
  int    exp_misses = 0;

  // L3 responder: fills after L3_LAT cycles, accepts write-backs at once and
  // compares each victim against the expected write-back queue.
  initial begin
    L3_ready = 1'b0;
    L3_write_back_verified = 1'b0;
    L3_read_data = '0;
    forever begin
      @(negedge clk);
      if (!reset && L3_read_request && !l3_stall) begin
        repeat (L3_LAT) @(negedge clk);
        L3_read_data = pat(L3_address);
        L3_ready = 1'b1;
        l3_rd_cnt++;
        @(negedge clk);
        L3_ready = 1'b0;
      end else if (!reset && L3_write_back_request) begin
        if (exp_wb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_l3_wb addr=%h", L3_address);
        end else begin
          wb_t e;
          e = exp_wb_q.pop_front();
          check("l3_wb_addr", L3_address, e.addr);
          check("l3_wb_data", L3_write_data, e.data);
        end
        l3_wb_cnt++;
        L3_write_back_verified = 1'b1;
        @(negedge clk);
        L3_write_back_verified = 1'b0;
      end
    end
  end

  // Response scoreboard: each pulse pops the oldest expectation.
  task automatic pop_check(input req_t k, input logic [127:0] data);
    if (resp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_response kind=%0d", k);
    end else begin
      resp_t r;
      r = resp_q.pop_front();
      check("resp_kind", k, r.kind);
      if (k == REQ_READ) check("resp_data", data, r.data);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (L2a_ready)                  pop_check(REQ_READ, write_data_to_L1a_from_L2a);
      if (write_to_L2a_verified)      pop_check(REQ_WRITE, '0);
      if (write_back_to_L2a_verified) pop_check(REQ_WB, '0);
    end
  end

  function automatic int sat_inc(input int v);
    return (v == (1 << SW) - 1) ? v : v + 1;
  endfunction

  task automatic check_counts();
    check("hit_count", L2a_hit_count, exp_hits[SW-1:0]);
    check("miss_count", L2a_miss_count, exp_misses[SW-1:0]);
  endtask

  task automatic drop_requests();
    read_from_L2a_request     = 1'b0;
    write_to_L2a_request      = 1'b0;
    write_back_to_L2a_request = 1'b0;
  endtask

  // Drives one request (called right after a negedge) and waits for its response.
  task automatic run_vec(input vec_t v);
    int    rd0, wb0, edges;
    bit    done, saw_hit, saw_miss;
    resp_t r;
    wb_t   w;
    rd0 = l3_rd_cnt;
    wb0 = l3_wb_cnt;
    edges = 0;
    done = 0;
    saw_hit = 0;
    saw_miss = 0;
    r.kind = v.kind;
    r.data = v.exp_rdata;
    resp_q.push_back(r);
    if (v.exp_wb) begin
      w.addr = v.exp_wb_addr;
      w.data = v.exp_wb_data;
      exp_wb_q.push_back(w);
    end
    cache_L2a_memory_address   = v.addr;
    cache_1a_write_data_to_L2a = v.wdata;
    write_back_to_L2a_data     = v.wbdata;
    read_from_L2a_request      = (v.kind == REQ_READ);
    write_to_L2a_request       = (v.kind == REQ_WRITE);
    write_back_to_L2a_request  = (v.kind == REQ_WB);
    while (!done && edges < TIMEOUT) begin
      @(negedge clk);
      edges++;
      saw_hit  |= L2a_cache_hit;
      saw_miss |= L2a_cache_miss;
      case (v.kind)
        REQ_READ:  done = L2a_ready;
        REQ_WRITE: done = write_to_L2a_verified;
        default:   done = write_back_to_L2a_verified;
      endcase
    end
    drop_requests();
    check("response_seen", done, 1'b1);
    check("hit_pulse", saw_hit, v.exp_hit);
    check("miss_pulse", saw_miss, !v.exp_hit);
    // Capture edge plus two cycles on a hit.
    if (v.exp_hit) check("hit_latency", edges - 1, 2);
    check("l3_fills", l3_rd_cnt - rd0, v.exp_fill);
    check("l3_wbs", l3_wb_cnt - wb0, v.exp_wb);
    if (v.exp_hit) exp_hits = sat_inc(exp_hits);
    else           exp_misses = sat_inc(exp_misses);
    check_counts();
  endtask

  function automatic vec_t mk(input req_t k, input logic [31:0] a, input logic [31:0] wd,
                              input logic [127:0] wbd, input bit h, input bit f, input bit wb,
                              input logic [31:0] wa, input logic [127:0] wdat,
                              input logic [127:0] rd);
    vec_t v;
    v.kind = k; v.addr = a; v.wdata = wd; v.wbdata = wbd;
    v.exp_hit = h; v.exp_fill = f; v.exp_wb = wb;
    v.exp_wb_addr = wa; v.exp_wb_data = wdat; v.exp_rdata = rd;
    return v;
  endfunction

  localparam logic [127:0] BLK_B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] BLK_C = 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF;
  localparam logic [127:0] BLK_D = 128'hD0D0_0000_D1D1_1111_D2D2_2222_D3D3_3333;
  localparam logic [127:0] BLK_E = 128'hE1E2_E3E4_E5E6_E7E8_E9EA_EBEC_EDEE_EFF0;
  localparam logic [127:0] MERGED_40   = {32'hA000_0040, 32'hDEAD_BEEF, 32'hA000_0040, 32'hA000_0040};
  localparam logic [127:0] MERGED_1080 = {32'hA000_1080, 32'hA000_1080, 32'h1234_5678, 32'hA000_1080};

  vec_t vecs[13];

  initial begin
    int edges, wb_at, rd_at;
    bit seen, activity;
    resp_t r;
    wb_t   w;

    vecs[0]  = mk(REQ_READ,  32'h0000_0040, 0, 0, 0, 1, 0, 0, 0, pat(32'h40));
    vecs[1]  = mk(REQ_READ,  32'h0000_0040, 0, 0, 1, 0, 0, 0, 0, pat(32'h40));
    vecs[2]  = mk(REQ_WRITE, 32'h0000_0048, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(REQ_READ,  32'h0000_0040, 0, 0, 1, 0, 0, 0, 0, MERGED_40);
    vecs[4]  = mk(REQ_READ,  32'h0000_0440, 0, 0, 0, 1, 1, 32'h40, MERGED_40, pat(32'h440));
    vecs[5]  = mk(REQ_WRITE, 32'h0000_1084, 32'h1234_5678, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(REQ_READ,  32'h0000_1080, 0, 0, 1, 0, 0, 0, 0, MERGED_1080);
    vecs[7]  = mk(REQ_WB,    32'h0000_2000, 0, BLK_B, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(REQ_READ,  32'h0000_2000, 0, 0, 1, 0, 0, 0, 0, BLK_B);
    vecs[9]  = mk(REQ_WB,    32'h0000_2008, 0, BLK_C, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(REQ_READ,  32'h0000_2000, 0, 0, 1, 0, 0, 0, 0, BLK_C);
    vecs[11] = mk(REQ_WB,    32'h0000_2400, 0, BLK_E, 0, 0, 1, 32'h2000, BLK_C, 0);
    vecs[12] = mk(REQ_READ,  32'h0000_2400, 0, 0, 1, 0, 0, 0, 0, BLK_E);

    reset = 1'b1;
    drop_requests();
    cache_L2a_memory_address   = '0;
    cache_1a_write_data_to_L2a = '0;
    write_back_to_L2a_data     = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", write_data_to_L1a_from_L2a, '0);
    check("rst_l3_wdata", L3_write_data, '0);
    check("rst_ctrl", {L3_address, L3_read_request, L3_write_back_request, L2a_ready,
                       write_to_L2a_verified, write_back_to_L2a_verified, L2a_cache_hit,
                       L2a_cache_miss, L2a_hit_count, L2a_miss_count}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Foreign processor id: nothing may happen while the request is held.
    activity = 0;
    cache_L2a_memory_address = 32'h4000_0040;
    read_from_L2a_request = 1'b1;
    repeat (8) begin
      @(negedge clk);
      activity |= L3_read_request | L3_write_back_request | L2a_ready |
                  L2a_cache_hit | L2a_cache_miss;
    end
    drop_requests();
    check("foreign_id_ignored", activity, 1'b0);
    check_counts();

    // Simultaneous read + write-back to 0x440: write-back must win, and the
    // read that follows must return the block just written.
    r.kind = REQ_WB;   r.data = '0;    resp_q.push_back(r);
    r.kind = REQ_READ; r.data = BLK_D; resp_q.push_back(r);
    cache_L2a_memory_address = 32'h0000_0440;
    write_back_to_L2a_data   = BLK_D;
    read_from_L2a_request     = 1'b1;
    write_back_to_L2a_request = 1'b1;
    edges = 0; wb_at = 0; rd_at = 0;
    while (rd_at == 0 && edges < TIMEOUT) begin
      @(negedge clk);
      edges++;
      if (write_back_to_L2a_verified && wb_at == 0) begin
        wb_at = edges;
        write_back_to_L2a_request = 1'b0;
      end
      if (L2a_ready) begin
        rd_at = edges;
        read_from_L2a_request = 1'b0;
      end
    end
    drop_requests();
    check("prio_wb_seen", wb_at != 0, 1'b1);
    check("prio_rd_seen", rd_at != 0, 1'b1);
    check("prio_wb_first", (wb_at != 0) && (wb_at < rd_at), 1'b1);
    exp_hits = sat_inc(sat_inc(exp_hits));
    check_counts();

    // Drive the hit counter into saturation.
    for (int i = 0; i < 16; i++)
      run_vec(mk(REQ_READ, 32'h0000_0440, 0, 0, 1, 0, 0, 0, 0, BLK_D));
    check("hit_saturated", L2a_hit_count, {SW{1'b1}});

    // Reset during ALLOCATE: 0x3040 evicts dirty 0x440, then the fill stalls.
    l3_stall = 1;
    w.addr = 32'h0000_0440; w.data = BLK_D; exp_wb_q.push_back(w);
    cache_L2a_memory_address = 32'h0000_3040;
    read_from_L2a_request = 1'b1;
    seen = 0;
    edges = 0;
    while (!seen && edges < 50) begin
      @(negedge clk);
      edges++;
      seen = L3_read_request;
    end
    check("abort_alloc_reached", seen, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_l3_rd_drop", L3_read_request, 1'b0);
    check("abort_outputs", {L3_address, L3_write_back_request, L2a_ready, L2a_cache_hit,
                            L2a_cache_miss, L2a_hit_count, L2a_miss_count}, '0);
    drop_requests();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    l3_stall = 0;
    exp_hits = 0;
    exp_misses = 0;
    repeat (3) @(negedge clk);
    check("abort_no_response", resp_q.size(), 0);

    // Arrays were cleared, so 0x40 misses and fills again.
    run_vec(mk(REQ_READ, 32'h0000_0040, 0, 0, 0, 1, 0, 0, 0, pat(32'h40)));

    repeat (4) @(negedge clk);
    check("resp_queue_drained", resp_q.size(), 0);
    check("wb_queue_drained", exp_wb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
